// File: rtl/common_types_pkg.sv
// Shared types for the CPU/RAM memory path: word type, arbiter state and
// access-owner encodings, and the default RAM latency.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } ramstate_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int RAM_LAT = 2;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one fixed-latency single-port RAM between the instruction-fetch and
// data ports. Data wins ties unless it won the previous access.
module ram_arbiter
  import common_types_pkg::*;
#(
  parameter int LAT = RAM_LAT,
  parameter int CW  = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iren,
  input  word_t       iaddr,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        iwait,
  output logic        dwait,
  output word_t       iload,
  output word_t       dload,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output word_t       ram_addr,
  output word_t       ram_store,
  input  word_t       ram_load
);

  ramstate_t       state;
  ramstate_t       state_next;
  logic [CW-1:0]   cnt;
  logic            last_d;
  owner_t          owner;
  word_t           lat_addr;
  word_t           lat_store;
  logic [3:0]      lat_wen;

  logic            dreq;
  logic            is_write;
  logic            grant_d;
  logic            start;
  logic            abort;
  logic            complete;

  assign dreq     = dren | (dwen != 4'b0000);
  assign is_write = (lat_wen != 4'b0000);
  assign grant_d  = dreq & (~iren | ~last_d);
  assign start    = (state == IDLE) & (dreq | iren);

  // A read is abandoned as soon as its owner stops asking; writes always finish.
  assign abort    = (state == BUSY) & ~is_write &
                    ((owner == OWN_I) ? ~iren : ~dreq);
  assign complete = (state == BUSY) & (cnt == '0) & ~abort;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dreq | iren) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (abort || (cnt == '0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt       <= '0;
      last_d    <= 1'b0;
      owner     <= OWN_I;
      lat_addr  <= '0;
      lat_wen   <= '0;
      lat_store <= '0;
    end else begin
      if (start) begin
        owner     <= grant_d ? OWN_D : OWN_I;
        lat_addr  <= grant_d ? daddr : iaddr;
        lat_wen   <= grant_d ? dwen : 4'b0000;
        lat_store <= grant_d ? dstore : '0;
        cnt       <= CW'(LAT - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (complete) begin
        last_d <= (owner == OWN_D);
      end
    end
  end

  // The owner's wait drops in the same cycle the RAM presents its data.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 4'b0000;
    ram_addr  = '0;
    ram_store = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    if (state == BUSY) begin
      ram_addr  = lat_addr;
      ram_wen   = lat_wen;
      ram_store = lat_store;
      ram_ren   = ~is_write;
      if (complete) begin
        if (owner == OWN_I) begin
          iwait = 1'b0;
          iload = ram_load;
        end else begin
          dwait = 1'b0;
          if (!is_write) begin
            dload = ram_load;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural fixed-latency,
// byte-enabled RAM that commits a write once its inputs are held LAT cycles.
module tb_ram_arbiter;
  import common_types_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        nrst;
  logic        iren;
  word_t       iaddr;
  logic        dren;
  logic [3:0]  dwen;
  word_t       daddr;
  word_t       dstore;
  logic        iwait;
  logic        dwait;
  word_t       iload;
  word_t       dload;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  word_t       ram_addr;
  word_t       ram_store;
  word_t       ram_load;

  int passed;
  int total;

  ram_arbiter #(.LAT(LAT), .CW(4)) dut (
    .CLK(clk), .nRST(nrst),
    .iren(iren), .iaddr(iaddr),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  word_t      mem [0:4095];
  int         wstable;
  logic       p_active;
  logic [3:0] p_wen;
  word_t      p_addr;
  word_t      p_store;

  initial begin
    wstable  = 0;
    p_active = 1'b0;
    p_wen    = 4'b0000;
    p_addr   = '0;
    p_store  = '0;
  end

  assign ram_load = ram_ren ? mem[ram_addr[11:0]] : 32'h0;

  always @(posedge clk) begin
    if (ram_wen != 4'b0000) begin
      if (p_active && ram_wen == p_wen && ram_addr == p_addr && ram_store == p_store)
        wstable = wstable + 1;
      else
        wstable = 1;
      if (wstable == LAT) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) mem[ram_addr[11:0]][b*8 +: 8] = ram_store[b*8 +: 8];
      end
      p_active = 1'b1;
      p_wen    = ram_wen;
      p_addr   = ram_addr;
      p_store  = ram_store;
    end else begin
      p_active = 1'b0;
      wstable  = 0;
    end
  end

  // Runs one access from the start of an IDLE cycle and returns the cycle
  // index at which the owner's wait fell (-1 on timeout).
  task automatic run_access(input logic use_d, input logic rd, input logic [3:0] wen,
                            input word_t addr, input word_t store,
                            output int done_k, output word_t ldata, output logic other_low,
                            output logic [3:0] b_wen, output logic b_ren, output word_t b_addr);
    done_k = -1; ldata = '0; other_low = 1'b0;
    b_wen = 4'b0000; b_ren = 1'b0; b_addr = '0;
    if (use_d) begin
      dren = rd; dwen = wen; daddr = addr; dstore = store;
    end else begin
      iren = 1'b1; iaddr = addr;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        b_wen = ram_wen; b_ren = ram_ren; b_addr = ram_addr;
      end
      if ((use_d ? iwait : dwait) == 1'b0) other_low = 1'b1;
      if ((use_d ? dwait : iwait) == 1'b0) begin
        done_k = k;
        ldata  = use_d ? dload : iload;
      end
      @(posedge clk); #1;
      if (done_k >= 0) break;
    end
    iren = 1'b0; dren = 1'b0; dwen = 4'b0000;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ram_ren !== 1'b0) $display("[TB] FAIL rst_ram_ren got %0b want 0", ram_ren); else passed++;
    total++; if (ram_wen !== 4'h0) $display("[TB] FAIL rst_ram_wen got %h want 0", ram_wen); else passed++;
    total++; if (ram_addr !== 32'h0) $display("[TB] FAIL rst_ram_addr got %h want 0", ram_addr); else passed++;
    total++; if (ram_store !== 32'h0) $display("[TB] FAIL rst_ram_store got %h want 0", ram_store); else passed++;
    total++; if (iwait !== 1'b1) $display("[TB] FAIL rst_iwait got %0b want 1", iwait); else passed++;
    total++; if (dwait !== 1'b1) $display("[TB] FAIL rst_dwait got %0b want 1", dwait); else passed++;
    total++; if (iload !== 32'h0) $display("[TB] FAIL rst_iload got %h want 0", iload); else passed++;
    total++; if (dload !== 32'h0) $display("[TB] FAIL rst_dload got %h want 0", dload); else passed++;
    daddr = 32'h40; iaddr = 32'h80;
    #2 nrst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ram_addr !== 32'h40) $display("[TB] FAIL first_grant_addr got %h want 00000040", ram_addr); else passed++;
    total++; if (ram_ren !== 1'b1) $display("[TB] FAIL first_grant_ren got %0b want 1", ram_ren); else passed++;
    total++; if (dwait !== 1'b1) $display("[TB] FAIL first_grant_dwait_c1 got %0b want 1", dwait); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (dwait !== 1'b0) $display("[TB] FAIL first_grant_dwait_c2 got %0b want 0", dwait); else passed++;
    total++; if (iwait !== 1'b1) $display("[TB] FAIL first_grant_iwait_c2 got %0b want 1", iwait); else passed++;
    @(posedge clk); #1;
    iren = 1'b0; dren = 1'b0;
  endtask

  task automatic test_write_full();
    int k; word_t d; logic ol; logic [3:0] bw; logic br; word_t ba;
    run_access(1'b1, 1'b0, 4'hF, 32'h100, 32'hDEADBEEF, k, d, ol, bw, br, ba);
    total++; if (k !== LAT) $display("[TB] FAIL wr100_latency got %0d want %0d", k, LAT); else passed++;
    total++; if (d !== 32'h0) $display("[TB] FAIL wr100_dload got %h want 0", d); else passed++;
    run_access(1'b1, 1'b0, 4'hF, 32'h200, 32'h11223344, k, d, ol, bw, br, ba);
    total++; if (k !== LAT) $display("[TB] FAIL wr200_latency got %0d want %0d", k, LAT); else passed++;
  endtask

  task automatic test_byte_write();
    int k; word_t d; logic ol; logic [3:0] bw; logic br; word_t ba;
    run_access(1'b1, 1'b1, 4'b0011, 32'h200, 32'hAABBCCDD, k, d, ol, bw, br, ba);
    total++; if (k !== LAT) $display("[TB] FAIL bw_latency got %0d want %0d", k, LAT); else passed++;
    total++; if (bw !== 4'b0011) $display("[TB] FAIL bw_ram_wen got %b want 0011", bw); else passed++;
    total++; if (br !== 1'b0) $display("[TB] FAIL bw_ram_ren got %0b want 0", br); else passed++;
    total++; if (ba !== 32'h200) $display("[TB] FAIL bw_ram_addr got %h want 00000200", ba); else passed++;
    total++; if (d !== 32'h0) $display("[TB] FAIL bw_dload got %h want 0", d); else passed++;
    run_access(1'b1, 1'b1, 4'b0000, 32'h200, 32'h0, k, d, ol, bw, br, ba);
    total++; if (d !== 32'h1122CCDD) $display("[TB] FAIL bw_readback got %h want 1122ccdd", d); else passed++;
    total++; if (br !== 1'b1) $display("[TB] FAIL rd_ram_ren got %0b want 1", br); else passed++;
  endtask

  task automatic test_single_fetch();
    int k; word_t d; logic ol; logic [3:0] bw; logic br; word_t ba;
    run_access(1'b0, 1'b1, 4'b0000, 32'h100, 32'h0, k, d, ol, bw, br, ba);
    total++; if (k !== 2) $display("[TB] FAIL fetch_latency got %0d want 2", k); else passed++;
    total++; if (d !== 32'hDEADBEEF) $display("[TB] FAIL fetch_iload got %h want deadbeef", d); else passed++;
    total++; if (ol !== 1'b0) $display("[TB] FAIL fetch_dwait_low got %0b want 0", ol); else passed++;
    @(negedge clk);
    total++; if (ram_ren !== 1'b0) $display("[TB] FAIL fetch_c3_idle_ren got %0b want 0", ram_ren); else passed++;
    total++; if (iwait !== 1'b1) $display("[TB] FAIL fetch_c3_iwait got %0b want 1", iwait); else passed++;
    total++; if (iload !== 32'h0) $display("[TB] FAIL fetch_c3_iload got %h want 0", iload); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int    n;
    int    cyc [4];
    logic  who [4];
    word_t dat [4];
    logic  both_low;
    n = 0; both_low = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc[i] = -1; who[i] = 1'b0; dat[i] = '0; end
    iren = 1'b1; dren = 1'b1; dwen = 4'b0000; iaddr = 32'h100; daddr = 32'h200;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (!iwait && !dwait) both_low = 1'b1;
      if (!dwait) begin
        cyc[n] = k; who[n] = 1'b1; dat[n] = dload; n++;
      end else if (!iwait) begin
        cyc[n] = k; who[n] = 1'b0; dat[n] = iload; n++;
      end
      @(posedge clk); #1;
    end
    iren = 1'b0; dren = 1'b0;
    total++; if (n !== 4) $display("[TB] FAIL cont_count got %0d want 4", n); else passed++;
    total++; if (both_low !== 1'b0) $display("[TB] FAIL cont_both_low got %0b want 0", both_low); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++; if (who[i] !== ((i % 2) == 0)) $display("[TB] FAIL cont_owner[%0d] got %0b want %0b", i, who[i], ((i % 2) == 0)); else passed++;
      total++; if (cyc[i] !== 2 + 3 * i) $display("[TB] FAIL cont_cycle[%0d] got %0d want %0d", i, cyc[i], 2 + 3 * i); else passed++;
      total++; if (dat[i] !== (((i % 2) == 0) ? 32'h1122CCDD : 32'hDEADBEEF))
        $display("[TB] FAIL cont_data[%0d] got %h want %h", i, dat[i], (((i % 2) == 0) ? 32'h1122CCDD : 32'hDEADBEEF)); else passed++;
    end
  endtask

  task automatic test_abort();
    iren = 1'b1; iaddr = 32'h100;
    @(posedge clk); #1;
    iren = 1'b0; dren = 1'b1; daddr = 32'h200;
    @(negedge clk);
    total++; if (iwait !== 1'b1) $display("[TB] FAIL abort_c1_iwait got %0b want 1", iwait); else passed++;
    total++; if (ram_addr !== 32'h100) $display("[TB] FAIL abort_c1_addr got %h want 00000100", ram_addr); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ram_ren !== 1'b0) $display("[TB] FAIL abort_c2_idle_ren got %0b want 0", ram_ren); else passed++;
    total++; if (iwait !== 1'b1) $display("[TB] FAIL abort_c2_iwait got %0b want 1", iwait); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (ram_addr !== 32'h200) $display("[TB] FAIL abort_c3_daddr got %h want 00000200", ram_addr); else passed++;
    total++; if (ram_ren !== 1'b1) $display("[TB] FAIL abort_c3_ren got %0b want 1", ram_ren); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (dwait !== 1'b0) $display("[TB] FAIL abort_c4_dwait got %0b want 0", dwait); else passed++;
    total++; if (dload !== 32'h1122CCDD) $display("[TB] FAIL abort_c4_dload got %h want 1122ccdd", dload); else passed++;
    total++; if (iwait !== 1'b1) $display("[TB] FAIL abort_c4_iwait got %0b want 1", iwait); else passed++;
    @(posedge clk); #1;
    dren = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int k; word_t d; logic ol; logic [3:0] bw; logic br; word_t ba;
    run_access(1'b1, 1'b0, 4'hF, 32'h300, 32'h55667788, k, d, ol, bw, br, ba);
    total++; if (k !== LAT) $display("[TB] FAIL wr300_latency got %0d want %0d", k, LAT); else passed++;
    dwen = 4'hF; daddr = 32'h300; dstore = 32'hCAFEF00D;
    @(posedge clk); #1;
    total++; if (ram_wen !== 4'hF) $display("[TB] FAIL midrst_busy_wen got %h want f", ram_wen); else passed++;
    #2 nrst = 1'b0;
    #1;
    total++; if (ram_wen !== 4'h0) $display("[TB] FAIL midrst_ram_wen got %h want 0", ram_wen); else passed++;
    total++; if (ram_addr !== 32'h0) $display("[TB] FAIL midrst_ram_addr got %h want 0", ram_addr); else passed++;
    total++; if (ram_store !== 32'h0) $display("[TB] FAIL midrst_ram_store got %h want 0", ram_store); else passed++;
    total++; if (dwait !== 1'b1) $display("[TB] FAIL midrst_dwait got %0b want 1", dwait); else passed++;
    dwen = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (mem[12'h300] !== 32'h55667788) $display("[TB] FAIL midrst_mem got %h want 55667788", mem[12'h300]); else passed++;
    nrst = 1'b1;
    run_access(1'b1, 1'b1, 4'b0000, 32'h300, 32'h0, k, d, ol, bw, br, ba);
    total++; if (d !== 32'h55667788) $display("[TB] FAIL midrst_readback got %h want 55667788", d); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    nrst = 1'b0;
    iren = 1'b1; dren = 1'b1; dwen = 4'b0000;
    iaddr = '0; daddr = '0; dstore = '0;
    test_reset();
    test_write_full();
    test_byte_write();
    test_single_fetch();
    test_contention();
    test_abort();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Memory-controller side of cpu_ram_if; connects to its ramctrl modport.
- Shares one single-port, fixed-latency RAM between the CPU instruction-fetch port and the CPU data port.
- Serialises accesses and drives iwait/dwait until the selected access completes.
- Data port has priority; alternation on contention prevents fetch starvation.

Parameters:
- LAT, 2, RAM access latency in cycles (legal range >=1). Inputs must be held stable for LAT cycles before ram_load is valid.
- CW, 4, counter width; must satisfy 2^CW > LAT.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iren  in  1  instruction read request.
- iaddr  in  32  instruction word address (word_t).
- dren  in  1  data read request.
- dwen  in  4  data byte-write enables; nonzero means write.
- daddr  in  32  data address (word_t).
- dstore  in  32  data write value (word_t).
- iwait  out  1  instruction access not complete this cycle.
- dwait  out  1  data access not complete this cycle.
- iload  out  32  instruction read data.
- dload  out  32  data read data.
- ram_ren  out  1  RAM read enable.
- ram_wen  out  4  RAM byte-write enables.
- ram_addr  out  32  RAM address.
- ram_store  out  32  RAM write data.
- ram_load  in  32  RAM read data; valid on the final cycle of an access.

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, cnt=0, last_d=0, owner=OWN_I.
  - Latched addr/wen/store cleared to 0.
  - Outputs: ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, iwait=1, dwait=1, iload=0, dload=0.
  - Reset mid-access abandons the access; no write completes after nRST falls.
- Request decode:
  - dreq = dren | (dwen != 0).
  - When dwen != 0, dren is ignored and the access is a write.
- State IDLE:
  - RAM outputs idle (all zero).
  - If both dreq and iren are high: grant I when last_d=1, otherwise grant D.
  - If only one request is high, grant that requester.
  - On grant: latch owner, address, wen, store; load cnt=LAT-1; go to BUSY.
  - Both waits stay 1 in IDLE. Minimum latency is LAT+1 cycles from request to wait low.
- State BUSY:
  - ram_addr, ram_store, ram_wen are driven from the latched values.
  - ram_ren = 1 for reads.
  - While cnt != 0: decrement cnt.
  - When cnt == 0: the owner's wait goes low combinationally, and iload or dload = ram_load for a read.
  - Then go to IDLE and set last_d = (owner==OWN_D).
  - The non-owner's wait stays 1 throughout.
- Abort: if the owner's request deasserts during a BUSY read (e.g. fetch flush), go to IDLE next cycle with no completion and last_d unchanged. Writes always complete from the latched values.
- Address or data changes during BUSY are ignored; latched values are used.
- iload/dload are 0 except in the owner's completion cycle.
- Turnaround: there is always exactly one IDLE cycle between accesses. Back-to-back throughput is one access per LAT+1 cycles.
- LAT=1: cnt loads 0, so completion occurs in the first BUSY cycle.

Decomposition:
- common_types_pkg gains:
  - ramstate_t enum {IDLE, BUSY}.
  - owner_t enum {OWN_I, OWN_D}.
  - RAM_LAT default constant.
- No RTL sub-module; the counter and latch registers live in the block.
- The bench uses a separate ram_model: a fixed-LAT, byte-enabled behavioural RAM.

Test Plan:
- Reset check: nRST low with iren=1 and dren=1 -> all ram_* outputs 0, iwait=dwait=1, iload=dload=0. On release, the first grant is D.
- Single fetch, LAT=2, iaddr=0x100 holding 0xDEADBEEF -> iwait=1 for cycles 0-1, iwait=0 with iload=0xDEADBEEF in cycle 2, IDLE in cycle 3.
- Byte write: dwen=4'b0011, daddr=0x200, dstore=0xAABBCCDD over 0x11223344 -> subsequent read returns 0x1122CCDD. dren asserted together with dwen does not change the result.
- Contention: iren and dren held high continuously -> grants alternate D, I, D, I. Each completion is LAT+1 cycles apart, and neither wait is ever low in the same cycle as the other.
- Abort: fetch granted, iren dropped in the first BUSY cycle -> iwait never goes low, IDLE next cycle, and a pending data request is granted immediately after.
- Mid-access reset during a write to 0x300 -> RAM contents at 0x300 unchanged, and outputs return to reset values asynchronously.
